// File: rtl/chan_arbiter_pkg.sv
// Shared definitions for the channel arbiter: word width, header field layout
// and the one-hot FSM state encoding.
package chan_arbiter_pkg;

    localparam int WORD_W     = 16;
    localparam int HDR_FLAG   = 15;
    localparam int HDR_NUM_HI = 14;
    localparam int HDR_NUM_LO = 9;
    localparam int HDR_LEN_HI = 8;
    localparam int HDR_LEN_LO = 0;
    localparam int LEN_W      = HDR_LEN_HI - HDR_LEN_LO + 1;
    localparam int NUM_W      = HDR_NUM_HI - HDR_NUM_LO + 1;

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_HDR  = 5'b00010,
        S_HLAT = 5'b00100,
        S_DATA = 5'b01000,
        S_TAIL = 5'b10000
    } state_t;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [WORD_W-1:0] w);
        return w[HDR_LEN_HI:HDR_LEN_LO];
    endfunction

    function automatic logic [NUM_W-1:0] hdr_num(input logic [WORD_W-1:0] w);
        return w[HDR_NUM_HI:HDR_NUM_LO];
    endfunction

endpackage

// File: rtl/chan_arbiter_sync_fifo.sv
// Single-clock output FIFO with a free-slot count; read data is zero when empty
// so the merged stream idles at zero.
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     free
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign valid   = (count != '0);
    assign free    = CW'(DEPTH) - count;
    assign do_push = push && !full;
    assign do_pop  = pop && valid;
    assign rdata   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            // simultaneous push and pop leaves occupancy unchanged
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/chan_arbiter.sv
// Round-robin arbiter that pulls whole header+data blocks from NCH channel
// processors and merges them into one 16-bit valid/ready stream.
module chan_arbiter
    import chan_arbiter_pkg::*;
#(
    parameter int NCH = 16,
    parameter int OFD = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH-1:0]        req,
    output logic [NCH-1:0]        ack,
    input  logic [NCH*WORD_W-1:0] din,
    output logic [WORD_W-1:0]     dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy,
    output logic                  hdr_err,
    input  logic                  err_clr,
    output logic [15:0]           blk_cnt,
    output state_t                dbg_state
);
    // dout is a transfer when dout_valid && dout_ready at posedge clk; dout_valid
    // never depends on dout_ready and a presented word stays until it is taken.
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int FW = $clog2(OFD) + 1;

    state_t            state, state_nx;
    logic [PW-1:0]     grant, rr_ptr, pick;
    logic              pick_ok;
    logic [LEN_W-1:0]  rem;
    logic              ack_d;
    logic [FW-1:0]     free;
    logic [WORD_W-1:0] cap_word;
    logic              room, ack_any, push, blk_done, err_set;

    assign room      = (free >= FW'(2));
    assign cap_word  = din[grant*WORD_W +: WORD_W];
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // first requester at or after rr_ptr: scan downwards so the lowest offset wins
    always_comb begin
        int idx;
        idx     = 0;
        pick    = rr_ptr;
        pick_ok = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % NCH;
            if (req[idx]) begin
                pick    = PW'(idx);
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        ack_any  = 1'b0;
        push     = 1'b0;
        blk_done = 1'b0;
        err_set  = 1'b0;
        unique case (state)
            S_IDLE: if (pick_ok) state_nx = S_HDR;
            S_HDR: begin
                if (room) begin
                    ack_any  = 1'b1;
                    state_nx = S_HLAT;
                end
            end
            S_HLAT: begin
                if (cap_word[HDR_FLAG]) begin
                    push = 1'b1;
                    if (hdr_len(cap_word) == '0) begin
                        blk_done = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_DATA;
                    end
                end else begin
                    err_set  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_DATA: begin
                push = ack_d;
                if (rem != '0 && room) begin
                    ack_any = 1'b1;
                    if (rem == LEN_W'(1)) state_nx = S_TAIL;
                end
            end
            S_TAIL: begin
                push     = ack_d;
                blk_done = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < NCH; k++) ack[k] = ack_any && (grant == PW'(k));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            grant   <= '0;
            rr_ptr  <= '0;
            rem     <= '0;
            ack_d   <= 1'b0;
            hdr_err <= 1'b0;
            blk_cnt <= '0;
        end else begin
            state <= state_nx;
            ack_d <= ack_any;
            if (state == S_IDLE && pick_ok) grant <= pick;
            if (state == S_HLAT) rem <= hdr_len(cap_word);
            else if (ack_any && state == S_DATA) rem <= rem - LEN_W'(1);
            if (blk_done) begin
                blk_cnt <= blk_cnt + 16'd1;
                rr_ptr  <= (grant == PW'(NCH - 1)) ? '0 : grant + PW'(1);
            end
            if (err_set) hdr_err <= 1'b1;
            else if (err_clr) hdr_err <= 1'b0;
        end
    end

    sync_fifo #(.W(WORD_W), .DEPTH(OFD)) u_ofd (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (cap_word),
        .pop   (dout_ready),
        .rdata (dout),
        .valid (dout_valid),
        .free  (free)
    );

endmodule

// File: tb/tb_chan_arbiter.sv
// Bench for chan_arbiter: channel processor models, output scoreboard,
// table-driven single-block vectors, corner sequences and randomized rounds.
module tb_chan_arbiter;
    import chan_arbiter_pkg::*;

    localparam int NCH = 16;
    localparam int OFD = 16;
    localparam int W   = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    ack;
    logic [NCH*W-1:0]  din;
    logic [W-1:0]      dout;
    logic              dout_valid;
    logic              dout_ready = 1'b0;
    logic              busy;
    logic              hdr_err;
    logic              err_clr = 1'b0;
    logic [15:0]       blk_cnt;
    state_t            dbg_state;

    int checks = 0;
    int errors = 0;
    int ready_mode = 1;
    int exp_blk = 0;
    int m_rr = 0;
    int ack_cnt [NCH];

    logic [W-1:0] exp_q [$];
    logic [W-1:0] chq [NCH][$];
    logic [W-1:0] din_r [NCH];
    logic [NCH-1:0] req_r = '0;
    logic [W-1:0] exp_w;

    typedef struct {
        int   ch;
        int   len;
        logic good;
        int   exp_busy;
        int   exp_acks;
        logic exp_err;
    } vec_t;
    vec_t vecs [6];

    chan_arbiter #(.NCH(NCH), .OFD(OFD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .ack        (ack),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .hdr_err    (hdr_err),
        .err_clr    (err_clr),
        .blk_cnt    (blk_cnt),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #4 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    assign req = req_r;
    always_comb begin
        for (int k = 0; k < NCH; k++) din[k*W +: W] = din_r[k];
    end

    initial begin
        for (int k = 0; k < NCH; k++) begin
            din_r[k]   = '0;
            ack_cnt[k] = 0;
        end
    end

    // channel processors: ack at cycle c presents the word on din at c+1
    always @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (rst_n && ack[k] && chq[k].size() != 0) din_r[k] <= chq[k].pop_front();
            req_r[k] <= (chq[k].size() != 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // sink driver + scoreboard + ack bookkeeping, all sampled at negedge
    always @(negedge clk) begin
        case (ready_mode)
            0:       dout_ready = 1'b0;
            1:       dout_ready = 1'b1;
            default: dout_ready = 1'($urandom_range(0, 1));
        endcase
        if (rst_n) begin
            checks++;
            if (!$onehot0(ack)) begin
                errors++;
                $display("FAIL ack_onehot: got 0x%0h, expected at most one bit", ack);
            end
            for (int k = 0; k < NCH; k++) begin
                if (ack[k]) begin
                    ack_cnt[k]++;
                    checks++;
                    if (chq[k].size() == 0) begin
                        errors++;
                        $display("FAIL ack_empty_chan: ch %0d acked with 0 words queued, expected >0", k);
                    end
                end
            end
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dout_extra: got 0x%0h, expected no word", dout);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("dout_word", 32'(dout), 32'(exp_w));
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load_block(input int ch, input int len, input int adc, input logic good,
                              input logic with_data);
        logic [W-1:0] hdr, w;
        hdr = {good, 6'(adc), 9'(len)};
        chq[ch].push_back(hdr);
        if (good) exp_q.push_back(hdr);
        if (with_data) begin
            for (int i = 0; i < len; i++) begin
                w = W'($urandom);
                chq[ch].push_back(w);
                if (good) exp_q.push_back(w);
            end
        end
        if (good) begin
            exp_blk = (exp_blk + 1) & 16'hffff;
            m_rr    = (ch + 1) % NCH;
        end
    endtask

    task automatic measure_block(output int ncyc);
        int t;
        t    = 0;
        ncyc = 0;
        while (!busy && t < 40) begin
            tick();
            t++;
        end
        while (busy && ncyc < 400) begin
            tick();
            ncyc++;
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while ((busy || dout_valid || req != '0 || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_drain_in_time"}, 32'(n < budget), 32'd1);
        check({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n, a0, a1, t;
        int cnt [NCH];
        int left, rr, k;

        vecs[0] = '{3,  5,  1'b1, 8,  6,  1'b0};
        vecs[1] = '{0,  0,  1'b1, 2,  1,  1'b0};
        vecs[2] = '{15, 3,  1'b1, 6,  4,  1'b0};
        vecs[3] = '{7,  5,  1'b0, 2,  1,  1'b1};
        vecs[4] = '{1,  12, 1'b1, 15, 13, 1'b1};
        vecs[5] = '{10, 1,  1'b1, 4,  2,  1'b1};

        rst_n = 1'b0;
        ready_mode = 1;
        repeat (3) tick();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hdr_err", 32'(hdr_err), 32'd0);
        check("rst_blk_cnt", 32'(blk_cnt), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        rst_n = 1'b1;
        repeat (2) tick();

        // single-block vectors
        for (int v = 0; v < 6; v++) begin
            a0 = ack_cnt[vecs[v].ch];
            load_block(vecs[v].ch, vecs[v].len, 3, vecs[v].good, vecs[v].good);
            measure_block(n);
            check($sformatf("vec%0d_busy_cycles", v), 32'(n), 32'(vecs[v].exp_busy));
            check($sformatf("vec%0d_acks", v), 32'(ack_cnt[vecs[v].ch] - a0), 32'(vecs[v].exp_acks));
            wait_drain(200, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_blk_cnt", v), 32'(blk_cnt), 32'(exp_blk));
            check($sformatf("vec%0d_hdr_err", v), 32'(hdr_err), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d_idle", v), 32'(dbg_state), 32'(S_IDLE));
        end

        // sticky error clear, then set-beats-clear on the same cycle
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clear", 32'(hdr_err), 32'd0);
        load_block(6, 5, 3, 1'b0, 1'b0);
        t = 0;
        while (dbg_state != S_HLAT && t < 20) begin
            tick();
            t++;
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_set_wins", 32'(hdr_err), 32'd1);
        wait_drain(100, "err");
        check("err_blk_cnt", 32'(blk_cnt), 32'(exp_blk));

        // reset in the middle of an L=10 block
        a0 = ack_cnt[5];
        load_block(5, 10, 12, 1'b1, 1'b1);
        t = 0;
        while (ack_cnt[5] - a0 < 4 && t < 50) begin
            tick();
            t++;
        end
        check("midrst_reached_word3", 32'(ack_cnt[5] - a0), 32'd4);
        rst_n = 1'b0;
        #1;
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_dout", 32'(dout), 32'd0);
        check("midrst_dout_valid", 32'(dout_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hdr_err", 32'(hdr_err), 32'd0);
        check("midrst_blk_cnt", 32'(blk_cnt), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(S_IDLE));
        for (int c = 0; c < NCH; c++) chq[c].delete();
        exp_q.delete();
        exp_blk = 0;
        m_rr = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // ch0 and ch2 together from rr_ptr 0, then ch1 and ch3 (rr_ptr now 3)
        load_block(0, 4, 1, 1'b1, 1'b1);
        load_block(2, 6, 2, 1'b1, 1'b1);
        wait_drain(200, "rr_a");
        check("rr_a_blk_cnt", 32'(blk_cnt), 32'd2);
        load_block(3, 3, 4, 1'b1, 1'b1);
        load_block(1, 2, 5, 1'b1, 1'b1);
        wait_drain(200, "rr_b");
        check("rr_b_blk_cnt", 32'(blk_cnt), 32'd4);

        // sink stalled on an L=40 block
        ready_mode = 0;
        tick();
        a0 = ack_cnt[2];
        load_block(2, 40, 9, 1'b1, 1'b1);
        repeat (100) tick();
        a1 = ack_cnt[2] - a0;
        check("stall_acks_max", 32'(a1 <= OFD), 32'd1);
        check("stall_acks_min", 32'(a1 >= OFD - 1), 32'd1);
        check("stall_dout_valid", 32'(dout_valid), 32'd1);
        check("stall_busy", 32'(busy), 32'd1);
        ready_mode = 1;
        wait_drain(400, "stall");
        check("stall_total_acks", 32'(ack_cnt[2] - a0), 32'd41);
        check("stall_blk_cnt", 32'(blk_cnt), 32'(exp_blk));

        // randomized rounds: expected order from the round-robin rule
        ready_mode = 2;
        for (int r = 0; r < 3; r++) begin
            left = 0;
            for (int c = 0; c < NCH; c++) begin
                cnt[c] = $urandom_range(0, 2);
                left += cnt[c];
            end
            rr = m_rr;
            while (left > 0) begin
                k = rr;
                while (cnt[k] == 0) k = (k + 1) % NCH;
                load_block(k, $urandom_range(1, 24), $urandom_range(0, 63), 1'b1, 1'b1);
                cnt[k]--;
                left--;
                rr = (k + 1) % NCH;
            end
            wait_drain(20000, $sformatf("rand%0d", r));
            check($sformatf("rand%0d_blk_cnt", r), 32'(blk_cnt), 32'(exp_blk));
            check($sformatf("rand%0d_hdr_err", r), 32'(hdr_err), 32'd0);
        end

        ready_mode = 1;
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chan_arbiter.md
CHAN_ARBITER -- requirements
Module: chan_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 16, meaning the number of channel processors served (1..64).
REQ-002 SHALL have parameter OFD, default 16, meaning the output FIFO depth in 16-bit words (power of 2, at least 4).
REQ-003 SHALL have port clk, input, 1 bit: 125MHz system clock; one clock, all logic on posedge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, NCH bits: per-channel "complete block available".
REQ-006 SHALL have port ack, output, NCH bits: per-channel read strobe, one word per cycle high.
REQ-007 SHALL have port din, input, NCH*16 bits: channel k word on din[16k+15:16k], registered in the channel and lagging its read pointer by 1 clk.
REQ-008 SHALL have port dout, output, 16 bits: merged block stream word.
REQ-009 SHALL have port dout_valid, output, 1 bit: dout holds a word.
REQ-010 SHALL have port dout_ready, input, 1 bit: sink accepts; a transfer occurs when dout_valid and dout_ready are both high.
REQ-011 SHALL have port busy, output, 1 bit: a block transfer is in progress.
REQ-012 SHALL have port hdr_err, output, 1 bit: sticky flag, set when a header word has bit15 = 0.
REQ-013 SHALL have port err_clr, input, 1 bit: synchronous clear of hdr_err.
REQ-014 SHALL have port blk_cnt, output, 16 bits: count of blocks forwarded, wraps at 0xFFFF -> 0.

Function
REQ-015 Header format SHALL be [15]=1, [14:9]=ADC number, [8:0]=L, followed by exactly L words; a block totals L+1 words.
REQ-016 Word capture rule SHALL be: the word read by ack[k] in cycle c is sampled from din[k] in cycle c+1, and at most one ack bit is high per cycle.
REQ-017 FSM states SHALL be IDLE, HDR, HLAT, DATA, TAIL, held in a one-hot register.
REQ-018 In IDLE with any req high, the FSM SHALL grant the first requesting channel at or after rr_ptr (wrapping modulo NCH) and move to HDR.
REQ-019 In HDR the FSM SHALL raise ack[grant] for one cycle when OFD free is at least 2, then move to HLAT; otherwise it SHALL wait in HDR with ack low.
REQ-020 In HLAT the FSM SHALL capture the header; if bit15 = 1 it SHALL push the header, load rem = L, and go to DATA, or go to IDLE when L = 0 (block complete).
REQ-021 In HLAT with bit15 = 0 the FSM SHALL drop the word, set hdr_err, not count a block, and go to IDLE.
REQ-022 In DATA the FSM SHALL assert ack[grant] in each cycle where rem > 0 and OFD free is at least 2, and decrement rem per ack.
REQ-023 In DATA, when the ack taking rem from 1 to 0 is issued, the FSM SHALL go to TAIL.
REQ-024 In DATA, each captured word (ack delayed by 1) SHALL be pushed to the OFD.
REQ-025 In TAIL the FSM SHALL push the last word, increment blk_cnt, set rr_ptr = grant+1 mod NCH, and go to IDLE.
REQ-026 The grant SHALL be held for the whole block; req falling mid-block SHALL be ignored and all L+1 words SHALL still be read.
REQ-027 An unstalled block of L+1 words SHALL occupy L+4 cycles from IDLE-with-req to return to IDLE.
REQ-028 The output stream SHALL hold whole blocks in arrival order, with no interleaving between channels.
REQ-029 OFD full SHALL never overflow, guaranteed by the free-at-least-2 ack gate; OFD empty SHALL drive dout_valid = 0.
REQ-030 On a simultaneous OFD push and pop, occupancy SHALL be unchanged.
REQ-031 busy SHALL be high in every state except IDLE.
REQ-032 If err_clr coincides with a new error, set SHALL win.

Reset
REQ-033 rst_n low SHALL asynchronously force: FSM to IDLE, ack = 0, dout = 0, dout_valid = 0, busy = 0, hdr_err = 0, blk_cnt = 0, rr_ptr = 0, rem = 0, and OFD empty.
REQ-034 Reset mid-block SHALL abandon the partial block; channel-side recovery is outside this block's scope.
REQ-035 Reset deassertion SHALL be synchronised externally; the first grant SHALL be possible on the 2nd clk after release.

Structure
REQ-036 A shared package SHALL hold the FSM state encodings, the header field positions (HDR_FLAG=15, HDR_NUM=14:9, HDR_LEN=8:0), and the word width of 16.
REQ-037 The block SHALL contain one sub-module, sync_fifo: a 16-bit x OFD single-clock FIFO exposing a free count, with async active-low reset.

Verification
REQ-038 Ch3 block header 0x8605 plus 5 words, dout_ready = 1 -> ack[3] high 6 cycles, 6 words out in order, blk_cnt = 1, 9 cycles total.
REQ-039 req = 0x0005 with rr_ptr = 0, each channel holding one block -> ch0 block fully precedes ch2 block; rr_ptr ends at 3.
REQ-040 Header 0x0605 (bit15 = 0) -> hdr_err = 1, nothing on dout, blk_cnt unchanged; err_clr -> hdr_err = 0.
REQ-041 dout_ready = 0 with an L = 40 block -> ack stops once 15 words (OFD minus 1) are stored; release drains all 41 words with no loss or duplication.
REQ-042 Header with L = 0 -> 1 word out, blk_cnt + 1, FSM back in IDLE after HLAT.
REQ-043 rst_n pulsed low at word 3 of an L = 10 block -> all outputs at reset values immediately; the next block is forwarded cleanly.
